// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and enumerations for the register-bank write scheduler.
// Included by the interface, the arbiter and the top level.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREGS  = 2 ** RF_ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Requester ids double as bit positions in the one-hot grant vector
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Writeback request bundle: ALU and load requesters, each with valid/ready plus address and data.
interface regfile_write_scheduler_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dir;
  logic [DATA_W-1:0] alu_di;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dir;
  logic [DATA_W-1:0] mem_di;

  modport master (
    output alu_valid, alu_dir, alu_di,
    output mem_valid, mem_dir, mem_di,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_dir, alu_di,
    input  mem_valid, mem_dir, mem_di,
    output alu_ready, mem_ready
  );

endinterface

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. It produces a one-hot grant and keeps a pointer to the last winner,
// so that on a conflict the requester that did not win last time is served.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_t rr_last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        grant = (rr_last == REQ_MEM) ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  // A grant is a completed transfer because ready is the grant and it implies valid
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= REQ_MEM;
    end else if (grant[REQ_ALU]) begin
      rr_last <= REQ_ALU;
    end else if (grant[REQ_MEM]) begin
      rr_last <= REQ_MEM;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register bank write port: clears every register after reset, then shares the port between
// ALU and load writebacks, and bypasses the registered write onto the bank read data.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int DATA_W         = RF_DATA_W,
  parameter int ADDR_W         = RF_ADDR_W,
  parameter int NREGS          = RF_NREGS,
  parameter bit CLEAR_ON_RESET = 1'b1
)(
  input  logic                      clk,
  input  logic                      rst,
  regfile_write_scheduler_if.slave  wb,
  input  logic [ADDR_W-1:0]         RA1,
  input  logic [ADDR_W-1:0]         RA2,
  input  logic [DATA_W-1:0]         DR1_in,
  input  logic [DATA_W-1:0]         DR2_in,
  output logic [DATA_W-1:0]         DR1,
  output logic [DATA_W-1:0]         DR2,
  output logic                      RW,
  output logic [ADDR_W-1:0]         dir,
  output logic [DATA_W-1:0]         di,
  output logic                      init_done
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        grant;
  logic              transfer;
  logic [ADDR_W-1:0] grant_dir;
  logic [DATA_W-1:0] grant_di;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == RUN),
    .req   ({wb.mem_valid, wb.alu_valid}),
    .grant (grant)
  );

  assign wb.alu_ready = grant[REQ_ALU];
  assign wb.mem_ready = grant[REQ_MEM];
  assign transfer     = |grant;
  assign grant_dir    = grant[REQ_MEM] ? wb.mem_dir : wb.alu_dir;
  assign grant_di     = grant[REQ_MEM] ? wb.mem_di  : wb.alu_di;

  // r0 is hardwired zero in the bank, so a write to it is accepted but never reaches the port
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? INIT : RUN;
      cnt   <= '0;
      RW    <= 1'b0;
      dir   <= '0;
      di    <= '0;
    end else begin
      case (state)
        INIT: begin
          RW  <= 1'b1;
          dir <= cnt;
          di  <= '0;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_REG) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (transfer) begin
            RW  <= (grant_dir != '0);
            dir <= grant_dir;
            di  <= grant_di;
          end else begin
            RW  <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign DR1       = (RW && (dir == RA1) && (RA1 != '0)) ? di : DR1_in;
  assign DR2       = (RW && (dir == RA2) && (RA2 != '0)) ? di : DR2_in;
  assign init_done = (state == RUN);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: expected bank writes are queued as stimulus is issued
// and a negedge monitor pops and compares them whenever the DUT asserts RW.
module tb_regfile_write_scheduler;

  typedef struct {
    logic [4:0]  dir;
    logic [31:0] di;
  } wr_t;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1, ra2;
  logic [31:0] dr1_in, dr2_in;
  logic [31:0] dr1, dr2;
  logic        rw;
  logic [4:0]  dir_out;
  logic [31:0] di_out;
  logic        init_done;

  int  n_checks = 0;
  int  n_fails  = 0;
  wr_t expq[$];

  regfile_write_scheduler_if wbif ();

  regfile_write_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wbif),
    .RA1       (ra1),
    .RA2       (ra2),
    .DR1_in    (dr1_in),
    .DR2_in    (dr2_in),
    .DR1       (dr1),
    .DR2       (dr2),
    .RW        (rw),
    .dir       (dir_out),
    .di        (di_out),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] adir, input logic [31:0] adi,
                               input logic mv, input logic [4:0] mdir, input logic [31:0] mdi);
    wbif.alu_valid = av;
    wbif.alu_dir   = adir;
    wbif.alu_di    = adi;
    wbif.mem_valid = mv;
    wbif.mem_dir   = mdir;
    wbif.mem_di    = mdi;
  endtask

  // Every write the bank sees must be the oldest outstanding expectation
  always @(negedge clk) begin
    wr_t e;
    if (rw === 1'b1) begin
      n_checks++;
      if (expq.size() == 0) begin
        n_fails++;
        $display("[TB] FAIL unexpected_write: got dir=%0d di=%h, expected no write", dir_out, di_out);
      end else begin
        e = expq.pop_front();
        if (dir_out !== e.dir || di_out !== e.di) begin
          n_fails++;
          $display("[TB] FAIL bank_write: got dir=%0d di=%h, expected dir=%0d di=%h",
                   dir_out, di_out, e.dir, e.di);
        end
      end
    end
  end

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rw_after_reset", {31'b0, rw}, 32'h0);
    checkOutput("init_done_reset", {31'b0, init_done}, 32'h0);
  endtask

  // Requests are held high during the clear to prove the readies stay low
  task automatic runInit();
    for (int i = 0; i < 32; i++) expq.push_back('{dir: 5'(i), di: 32'h0});
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      ra1    = 5'(i);
      dr1_in = 32'hA5A5_A5A5;
      #1;
      checkOutput("init_done", {31'b0, init_done}, (i == 31) ? 32'h1 : 32'h0);
      checkOutput("init_bypass", dr1, (i == 0) ? 32'hA5A5_A5A5 : 32'h0);
      if (i < 31) begin
        checkOutput("alu_ready_init", {31'b0, wbif.alu_ready}, 32'h0);
        checkOutput("mem_ready_init", {31'b0, wbif.mem_ready}, 32'h0);
      end
      if (i == 30) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    ra1    = '0;
    ra2    = '0;
    dr1_in = '0;
    dr2_in = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    $display("[TB] reset and register clear");
    doReset();
    runInit();

    $display("[TB] single ALU write with bypass");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    expq.push_back('{dir: 5'd5, di: 32'hDEAD_BEEF});
    #1;
    checkOutput("alu_ready_single", {31'b0, wbif.alu_ready}, 32'h1);
    checkOutput("mem_ready_single", {31'b0, wbif.mem_ready}, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    ra1    = 5'd5;
    dr1_in = 32'h1234_5678;
    #1;
    checkOutput("rw_alu_write", {31'b0, rw}, 32'h1);
    checkOutput("dr1_bypass", dr1, 32'hDEAD_BEEF);

    $display("[TB] load write to r0");
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h7);
    #1;
    checkOutput("mem_ready_r0", {31'b0, wbif.mem_ready}, 32'h1);
    checkOutput("alu_ready_r0", {31'b0, wbif.alu_ready}, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    ra2    = 5'd0;
    dr2_in = 32'h0000_0055;
    #1;
    checkOutput("rw_r0", {31'b0, rw}, 32'h0);
    checkOutput("dr2_no_bypass_r0", dr2, 32'h0000_0055);

    $display("[TB] round-robin conflict");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      #1;
      checkOutput("rr_alu_ready", {31'b0, wbif.alu_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput("rr_mem_ready", {31'b0, wbif.mem_ready}, (k % 2 == 0) ? 32'h0 : 32'h1);
      checkOutput("rr_not_both", {31'b0, wbif.alu_ready & wbif.mem_ready}, 32'h0);
      if (k % 2 == 0) expq.push_back('{dir: 5'd1, di: 32'h1});
      else            expq.push_back('{dir: 5'd2, di: 32'h2});
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    $display("[TB] reset in the middle of the clear");
    @(posedge clk);
    #1;
    doReset();
    for (int i = 0; i < 10; i++) expq.push_back('{dir: 5'(i), di: 32'h0});
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    doReset();
    runInit();

    $display("[TB] reset during a handshake");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("alu_ready_inflight", {31'b0, wbif.alu_ready}, 32'h1);
    doReset();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    runInit();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("write_queue_drained", 32'(expq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
